// File: rtl/brq_pkg.sv
// Shared types and constants for the branch resolve queue.
package brq_pkg;

  localparam int unsigned INSN_BYTES = 4;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } brq_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_tk;
    logic [31:0] pred_addr;
  } brq_entry_t;

endpackage

// File: rtl/brq_fifo.sv
// Prediction storage ring with wrap-bit pointers; clear empties the ring and beats push/pop.
module brq_fifo
  import brq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       push,
  input  brq_entry_t wdata,
  input  logic       pop,
  output brq_entry_t rdata_c,
  output logic       full_c,
  output logic       empty_c
);

  localparam int unsigned PW = AW + 1;

  logic [AW:0] head;
  logic [AW:0] tail;
  brq_entry_t  mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
    end
  end

  // Storage is not reset; only slots between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (push && !clear && !rst) mem[tail[AW-1:0]] <= wdata;
  end

  assign rdata_c = mem[head[AW-1:0]];
  assign full_c  = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
  assign empty_c = (head == tail);

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order branch prediction queue resolved at commit; drives predictor update and fetch redirect.
// Optional build macro BRQ_STATS_EN adds resolve/mispredict counters.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enq_valid,
  output logic        enq_ready,
  input  logic [31:0] enq_pc,
  input  logic        enq_pred_tk,
  input  logic [31:0] enq_pred_addr,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_pc,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic [31:0] upd_addr,
  output logic        flush_o,
  output logic [31:0] flush_addr_o,
  output logic        err_o
`ifdef BRQ_STATS_EN
  ,
  output logic [31:0] stat_resolved,
  output logic [31:0] stat_mispred
`endif
);

  brq_state_t  state;
  brq_entry_t  head_entry;
  brq_entry_t  new_entry;
  logic        full_c;
  logic        empty_c;
  logic        push_c;
  logic        resolve_c;
  logic        mispred_c;
  logic [31:0] nxt_c;

  assign enq_ready = !full_c && (state == RUN);
  assign res_ready = !empty_c;
  assign push_c    = enq_valid && enq_ready;
  assign resolve_c = res_valid && res_ready;

  assign new_entry = '{pc: enq_pc, pred_tk: enq_pred_tk, pred_addr: enq_pred_addr};

  assign nxt_c     = res_taken ? res_target : res_pc + 32'(INSN_BYTES);
  assign mispred_c = (head_entry.pred_tk != res_taken) ||
                     (res_taken && (head_entry.pred_addr != res_target));

  brq_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (resolve_c && mispred_c),
    .push    (push_c),
    .wdata   (new_entry),
    .pop     (resolve_c),
    .rdata_c (head_entry),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // Recovery FSM plus registered update/redirect pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      upd_valid    <= 1'b0;
      upd_pc       <= '0;
      upd_addr     <= '0;
      flush_o      <= 1'b0;
      flush_addr_o <= '0;
      err_o        <= 1'b0;
    end else begin
      upd_valid <= resolve_c && (res_taken || head_entry.pred_tk);
      flush_o   <= resolve_c && mispred_c;
      if (resolve_c) begin
        upd_pc   <= res_pc;
        upd_addr <= nxt_c;
        if (mispred_c) flush_addr_o <= nxt_c;
        if (res_pc != head_entry.pc) err_o <= 1'b1;
      end
      case (state)
        RUN:     if (resolve_c && mispred_c) state <= RECOVER;
        RECOVER: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef BRQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else if (resolve_c) begin
      stat_resolved <= stat_resolved + 32'd1;
      if (mispred_c) stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue: reset, resolve outcomes, flush/recover, wrap, pc mismatch.
`timescale 1ns/1ps
module tb_branch_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic        enq_pred_tk;
  logic [31:0] enq_pred_addr;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_addr;
  logic        flush_o;
  logic [31:0] flush_addr_o;
  logic        err_o;
`ifdef BRQ_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispred;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_queue dut (
    .clk           (clk),
    .rst           (rst),
    .enq_valid     (enq_valid),
    .enq_ready     (enq_ready),
    .enq_pc        (enq_pc),
    .enq_pred_tk   (enq_pred_tk),
    .enq_pred_addr (enq_pred_addr),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_pc        (res_pc),
    .res_taken     (res_taken),
    .res_target    (res_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_addr      (upd_addr),
    .flush_o       (flush_o),
    .flush_addr_o  (flush_addr_o),
    .err_o         (err_o)
`ifdef BRQ_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] addr);
    enq_valid = 1'b1; enq_pc = pc; enq_pred_tk = tk; enq_pred_addr = addr;
    cyc();
    enq_valid = 1'b0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    res_valid = 1'b1; res_pc = pc; res_taken = tk; res_target = tgt;
    cyc();
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enq_valid = 1'b1; enq_pc = 32'h500; enq_pred_tk = 1'b1; enq_pred_addr = 32'h600;
    res_valid = 1'b1; res_pc = 32'h500; res_taken = 1'b0; res_target = 32'h0;
    cyc();
    cyc();
    checks++; if (flush_o !== 1'b0)   begin errors++; $display("FAIL reset_flush got %b want 0", flush_o); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd got %b want 0", upd_valid); end
    checks++; if (enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got %b want 1", enq_ready); end
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL reset_res_ready got %b want 0", res_ready); end
    checks++; if (err_o !== 1'b0)     begin errors++; $display("FAIL reset_err got %b want 0", err_o); end
    enq_valid = 1'b0; res_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_correct_taken();
    push(32'h100, 1'b1, 32'h200);
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL t2_res_ready got %b want 1", res_ready); end
    resolve(32'h100, 1'b1, 32'h200);
    checks++; if (upd_valid !== 1'b1) begin errors++; $display("FAIL t2_upd_valid got %b want 1", upd_valid); end
    checks++; if (upd_pc !== 32'h100) begin errors++; $display("FAIL t2_upd_pc got %h want 00000100", upd_pc); end
    checks++; if (upd_addr !== 32'h200) begin errors++; $display("FAIL t2_upd_addr got %h want 00000200", upd_addr); end
    checks++; if (flush_o !== 1'b0)   begin errors++; $display("FAIL t2_flush got %b want 0", flush_o); end
    cyc();
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL t2_upd_pulse got %b want 0", upd_valid); end
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL t2_empty got %b want 0", res_ready); end
  endtask

  task automatic test_wrong_target();
    push(32'h40, 1'b1, 32'h30);
    push(32'h44, 1'b0, 32'h0);
    push(32'h48, 1'b0, 32'h0);
    push(32'h4C, 1'b0, 32'h0);
    // Same-cycle wrong-path push must be dropped by the flush.
    enq_valid = 1'b1; enq_pc = 32'h999; enq_pred_tk = 1'b0; enq_pred_addr = 32'h0;
    resolve(32'h40, 1'b1, 32'h80);
    enq_valid = 1'b0;
    checks++; if (flush_o !== 1'b1)        begin errors++; $display("FAIL t3_flush got %b want 1", flush_o); end
    checks++; if (flush_addr_o !== 32'h80) begin errors++; $display("FAIL t3_flush_addr got %h want 00000080", flush_addr_o); end
    checks++; if (upd_valid !== 1'b1)      begin errors++; $display("FAIL t3_upd_valid got %b want 1", upd_valid); end
    checks++; if (res_ready !== 1'b0)      begin errors++; $display("FAIL t3_queue_empty got %b want 0", res_ready); end
    checks++; if (enq_ready !== 1'b0)      begin errors++; $display("FAIL t3_recover_ready got %b want 0", enq_ready); end
    cyc();
    checks++; if (enq_ready !== 1'b1)      begin errors++; $display("FAIL t3_run_ready got %b want 1", enq_ready); end
    checks++; if (flush_o !== 1'b0)        begin errors++; $display("FAIL t3_flush_pulse got %b want 0", flush_o); end
    checks++; if (res_ready !== 1'b0)      begin errors++; $display("FAIL t3_still_empty got %b want 0", res_ready); end
  endtask

  task automatic test_nt_wrap();
    push(32'hFFFF_FFFC, 1'b1, 32'h1234);
    resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
    checks++; if (flush_o !== 1'b1)       begin errors++; $display("FAIL t4_flush got %b want 1", flush_o); end
    checks++; if (flush_addr_o !== 32'h0) begin errors++; $display("FAIL t4_flush_addr got %h want 00000000", flush_addr_o); end
    checks++; if (upd_valid !== 1'b1)     begin errors++; $display("FAIL t4_upd_valid got %b want 1", upd_valid); end
    checks++; if (upd_addr !== 32'h0)     begin errors++; $display("FAIL t4_upd_addr got %h want 00000000", upd_addr); end
    cyc();
  endtask

  task automatic test_full_wrap();
    int np;
    logic exp_ready;
    logic [31:0] epc;
    for (int i = 0; i < 8; i++) push(32'h1000 + 32'(4 * i), 1'b1, 32'h1100 + 32'(4 * i));
    checks++; if (enq_ready !== 1'b0) begin errors++; $display("FAIL t5_full_ready got %b want 0", enq_ready); end
    np = 8;
    for (int k = 0; k < 20; k++) begin
      exp_ready = (k != 0);
      checks++; if (enq_ready !== exp_ready) begin errors++; $display("FAIL t5_enq_ready k=%0d got %b want %b", k, enq_ready, exp_ready); end
      epc = 32'h1000 + 32'(4 * k);
      enq_valid = 1'b1; enq_pc = 32'h1000 + 32'(4 * np);
      enq_pred_tk = 1'b1; enq_pred_addr = 32'h1100 + 32'(4 * np);
      res_valid = 1'b1; res_pc = epc; res_taken = 1'b1; res_target = epc + 32'h100;
      cyc();
      if (exp_ready) np++;
      checks++; if (upd_valid !== 1'b1 || upd_pc !== epc || upd_addr !== epc + 32'h100) begin
        errors++; $display("FAIL t5_order k=%0d got %b %h %h want 1 %h %h", k, upd_valid, upd_pc, upd_addr, epc, epc + 32'h100);
      end
      checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL t5_flush k=%0d got %b want 0", k, flush_o); end
    end
    enq_valid = 1'b0; res_valid = 1'b0;
    do_reset();
  endtask

  task automatic test_empty_resolve();
    resolve(32'h700, 1'b1, 32'h800);
    checks++; if (upd_valid !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("FAIL empty_resolve got %b %b want 0 0", upd_valid, flush_o); end
  endtask

  task automatic test_pc_mismatch();
    push(32'h10, 1'b0, 32'h0);
    resolve(32'h14, 1'b0, 32'h0);
    checks++; if (err_o !== 1'b1)     begin errors++; $display("FAIL t6_err_set got %b want 1", err_o); end
    checks++; if (flush_o !== 1'b0)   begin errors++; $display("FAIL t6_flush got %b want 0", flush_o); end
    checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL t6_upd got %b want 0", upd_valid); end
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL t6_popped got %b want 0", res_ready); end
    push(32'h20, 1'b1, 32'h60);
    resolve(32'h20, 1'b1, 32'h60);
    cyc(); cyc();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL t6_err_sticky got %b want 1", err_o); end
    do_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL t6_err_clear got %b want 0", err_o); end
  endtask

  initial begin
    rst = 1'b1;
    enq_valid = 1'b0; enq_pc = '0; enq_pred_tk = 1'b0; enq_pred_addr = '0;
    res_valid = 1'b0; res_pc = '0; res_taken = 1'b0; res_target = '0;
    test_reset();
    test_correct_taken();
    test_wrong_target();
    test_nt_wrap();
    test_full_wrap();
    test_empty_resolve();
    test_pc_mismatch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
